// File: rtl/i2s_dsp_ws_det_if.sv
// Bus bundle for the DSP-mode I2S frame-sync detector.
// Optional err_cnt_o is present only when I2S_DSP_WS_DET_ERR_CNT_EN is defined.
interface i2s_dsp_ws_det_if #(
  parameter int ERR_CNT_W = 8
);
  // configuration and serial inputs
  logic       cfg_en_i;
  logic [4:0] cfg_num_bits_i;
  logic [3:0] cfg_num_words_i;
  logic       cfg_dsp_mode_i;
  logic       ws_i;
  logic       sd_i;
  // slot-aligned outputs
  logic       sd_o;
  logic       valid_o;
  logic [4:0] bit_idx_o;
  logic [3:0] word_idx_o;
  logic       word_last_o;
  logic       frame_last_o;
  logic       locked_o;
  logic       err_o;
`ifdef I2S_DSP_WS_DET_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_o;

  modport master (
    output cfg_en_i, cfg_num_bits_i, cfg_num_words_i, cfg_dsp_mode_i, ws_i, sd_i,
    input  sd_o, valid_o, bit_idx_o, word_idx_o, word_last_o, frame_last_o,
           locked_o, err_o, err_cnt_o
  );
  modport slave (
    input  cfg_en_i, cfg_num_bits_i, cfg_num_words_i, cfg_dsp_mode_i, ws_i, sd_i,
    output sd_o, valid_o, bit_idx_o, word_idx_o, word_last_o, frame_last_o,
           locked_o, err_o, err_cnt_o
  );
`else
  modport master (
    output cfg_en_i, cfg_num_bits_i, cfg_num_words_i, cfg_dsp_mode_i, ws_i, sd_i,
    input  sd_o, valid_o, bit_idx_o, word_idx_o, word_last_o, frame_last_o,
           locked_o, err_o
  );
  modport slave (
    input  cfg_en_i, cfg_num_bits_i, cfg_num_words_i, cfg_dsp_mode_i, ws_i, sd_i,
    output sd_o, valid_o, bit_idx_o, word_idx_o, word_last_o, frame_last_o,
           locked_o, err_o
  );
`endif
endinterface

// File: rtl/i2s_dsp_ws_det.sv
// Slave-side DSP/PCM frame-sync detector. Samples the 1-sck WS pulse, tracks
// bit/word slot position and emits registered per-slot strobes (latency 1)
// describing the sd_i bit sampled on the same edge. Flags early and
// stretched WS pulses.
// Optional feature macro: I2S_DSP_WS_DET_ERR_CNT_EN adds a saturating
// framing-error counter (err_cnt_o).
module i2s_dsp_ws_det #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                   sck_i,
  input  logic                   rstn_i,
  i2s_dsp_ws_det_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, HUNT, ACTIVE, GAP} state_t;

  state_t     state;
  logic       ws_q;
  logic       str_seen;   // current stretched pulse already flagged
  logic       pend;       // mode A: next edge is slot 0
  logic       mode_q;     // frame-latched dsp mode
  logic [4:0] nb;         // frame-latched bits-per-word minus 1
  logic [3:0] nw;         // frame-latched words-per-frame minus 1
  logic [4:0] bit_cnt;    // position of the last emitted slot
  logic [3:0] word_cnt;

  logic       rise, stretch;
  logic [4:0] cur_bit;
  logic [3:0] cur_word;
  logic       cur_wl, cur_last, a_legal, b0_wl, b0_last;

  assign rise    = bus.ws_i & ~ws_q;
  assign stretch = bus.ws_i &  ws_q;

  // Slot addressed by this edge when the frame simply keeps running
  always_comb begin
    cur_bit  = '0;
    cur_word = '0;
    if (!pend) begin
      if (bit_cnt == nb) begin
        cur_bit  = '0;
        cur_word = word_cnt + 4'd1;
      end else begin
        cur_bit  = bit_cnt + 5'd1;
        cur_word = word_cnt;
      end
    end
    cur_wl   = (cur_bit == nb);
    cur_last = cur_wl && (cur_word == nw);
    // mode A allows the next pulse on the frame-last edge itself
    a_legal  = !mode_q && cur_last;
    // strobes for a mode B slot 0 use the geometry being latched now
    b0_wl    = (bus.cfg_num_bits_i == 5'd0);
    b0_last  = b0_wl && (bus.cfg_num_words_i == 4'd0);
  end

  // Detector FSM with registered slot outputs
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state            <= IDLE;
      ws_q             <= 1'b0;
      str_seen         <= 1'b0;
      pend             <= 1'b0;
      mode_q           <= 1'b0;
      nb               <= '0;
      nw               <= '0;
      bit_cnt          <= '0;
      word_cnt         <= '0;
      bus.sd_o         <= 1'b0;
      bus.valid_o      <= 1'b0;
      bus.bit_idx_o    <= '0;
      bus.word_idx_o   <= '0;
      bus.word_last_o  <= 1'b0;
      bus.frame_last_o <= 1'b0;
      bus.locked_o     <= 1'b0;
      bus.err_o        <= 1'b0;
    end else begin
      ws_q             <= bus.ws_i;
      bus.sd_o         <= bus.cfg_en_i & bus.sd_i;
      bus.valid_o      <= 1'b0;
      bus.bit_idx_o    <= '0;
      bus.word_idx_o   <= '0;
      bus.word_last_o  <= 1'b0;
      bus.frame_last_o <= 1'b0;
      bus.err_o        <= 1'b0;
      if (!bus.ws_i) str_seen <= 1'b0;

      if (!bus.cfg_en_i) begin
        // disable wins over everything, including a simultaneous rise
        state        <= IDLE;
        pend         <= 1'b0;
        mode_q       <= 1'b0;
        nb           <= '0;
        nw           <= '0;
        bit_cnt      <= '0;
        word_cnt     <= '0;
        str_seen     <= 1'b0;
        bus.locked_o <= 1'b0;
      end else if (state == IDLE) begin
        state        <= HUNT;
        bus.locked_o <= 1'b0;
      end else begin
        // running slot is emitted unless an illegal mode A rise kills it
        if (state == ACTIVE && (!rise || a_legal)) begin
          bus.valid_o      <= 1'b1;
          bus.bit_idx_o    <= cur_bit;
          bus.word_idx_o   <= cur_word;
          bus.word_last_o  <= cur_wl;
          bus.frame_last_o <= cur_last;
        end

        if (rise) begin
          // frame start: HUNT/GAP always legal, ACTIVE only on mode A last slot
          bus.err_o    <= (state == ACTIVE) && !a_legal;
          bus.locked_o <= 1'b1;
          nb           <= bus.cfg_num_bits_i;
          nw           <= bus.cfg_num_words_i;
          mode_q       <= bus.cfg_dsp_mode_i;
          bit_cnt      <= '0;
          word_cnt     <= '0;
          if (bus.cfg_dsp_mode_i) begin
            // mode B: this edge is slot 0
            pend             <= 1'b0;
            state            <= b0_last ? GAP : ACTIVE;
            bus.valid_o      <= 1'b1;
            bus.bit_idx_o    <= '0;
            bus.word_idx_o   <= '0;
            bus.word_last_o  <= b0_wl;
            bus.frame_last_o <= b0_last;
          end else begin
            pend  <= 1'b1;
            state <= ACTIVE;
          end
        end else if (state == ACTIVE) begin
          bit_cnt  <= cur_bit;
          word_cnt <= cur_word;
          pend     <= 1'b0;
          state    <= cur_last ? GAP : ACTIVE;
        end

        // a held WS is reported once per pulse and never restarts the frame
        if (stretch && (state == ACTIVE || state == GAP) && !str_seen) begin
          bus.err_o <= 1'b1;
          str_seen  <= 1'b1;
        end
      end
    end
  end

`ifdef I2S_DSP_WS_DET_ERR_CNT_EN
  // Saturating count of framing-error pulses, cleared while idle
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i)
      bus.err_cnt_o <= '0;
    else if (state == IDLE)
      bus.err_cnt_o <= '0;
    else if (bus.err_o && (bus.err_cnt_o != {ERR_CNT_W{1'b1}}))
      bus.err_cnt_o <= bus.err_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_i2s_dsp_ws_det.sv
// Directed bench for i2s_dsp_ws_det: contiguous mode A/B frames, early-pulse
// resync, gap, stretched pulse, mid-frame config change and disable.
module tb_i2s_dsp_ws_det;

  logic sck;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  i2s_dsp_ws_det_if #(.ERR_CNT_W(8)) bus ();

  i2s_dsp_ws_det #(.ERR_CNT_W(8)) dut (
    .sck_i  (sck),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  function automatic logic [13:0] ex(input logic v, input logic [4:0] b,
                                     input logic [3:0] w, input logic wl,
                                     input logic fl, input logic lk, input logic er);
    return {v, b, w, wl, fl, lk, er};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one sck edge: drive ws/sd, then compare the slot outputs for that edge
  task automatic step(input string tag, input logic ws, input logic [13:0] exp);
    logic sd;
    sd = 1'($urandom_range(0, 1));
    bus.ws_i = ws;
    bus.sd_i = sd;
    @(posedge sck);
    #1;
    chk(tag, 32'({bus.valid_o, bus.bit_idx_o, bus.word_idx_o, bus.word_last_o,
                  bus.frame_last_o, bus.locked_o, bus.err_o}), 32'(exp));
    chk({tag, "_sd"}, 32'(bus.sd_o), 32'(bus.cfg_en_i ? sd : 1'b0));
  endtask

  // run slots s0..s1 of a frame with bpw bits/word and f slots; ws high at ws_at
  task automatic run(input string tag, input int s0, input int s1, input int bpw,
                     input int f, input int ws_at);
    for (int s = s0; s <= s1; s++)
      step($sformatf("%s_s%0d", tag, s), s == ws_at,
           ex(1'b1, 5'(s % bpw), 4'(s / bpw), (s % bpw) == bpw - 1, s == f - 1, 1'b1, 1'b0));
  endtask

  initial begin
    rstn                = 1'b0;
    bus.cfg_en_i        = 1'b0;
    bus.cfg_num_bits_i  = 5'd7;
    bus.cfg_num_words_i = 4'd1;
    bus.cfg_dsp_mode_i  = 1'b1;
    bus.ws_i            = 1'b0;
    bus.sd_i            = 1'b1;
    #12;
    chk("reset_out", 32'({bus.valid_o, bus.bit_idx_o, bus.word_idx_o, bus.word_last_o,
                          bus.frame_last_o, bus.locked_o, bus.err_o, bus.sd_o}), 32'd0);
`ifdef I2S_DSP_WS_DET_ERR_CNT_EN
    chk("reset_cnt", 32'(bus.err_cnt_o), 32'd0);
`endif
    @(negedge sck);
    rstn = 1'b1;
    bus.cfg_en_i = 1'b1;

    // 1: mode B, F=16, pulse every 16 edges
    step("t1_hunt", 1'b0, ex(0, 0, 0, 0, 0, 0, 0));
    step("t1_hunt2", 1'b0, ex(0, 0, 0, 0, 0, 0, 0));
    run("t1_f0", 0, 15, 8, 16, 0);
    run("t1_f1", 0, 15, 8, 16, 0);

    // 2: mode A, pulse on each frame-last edge
    bus.cfg_dsp_mode_i = 1'b0;
    step("t2_rise", 1'b1, ex(0, 0, 0, 0, 0, 1, 0));
    run("t2_f0", 0, 15, 8, 16, 15);
    run("t2_f1", 0, 15, 8, 16, -1);
    step("t2_gap", 1'b0, ex(0, 0, 0, 0, 0, 1, 0));

    // 3: mode B, early pulse at slot 9 resyncs with an error
    bus.cfg_dsp_mode_i = 1'b1;
    run("t3_pre", 0, 8, 8, 16, 0);
    step("t3_early", 1'b1, ex(1, 0, 0, 0, 0, 1, 1));
    run("t3_post", 1, 15, 8, 16, -1);
`ifdef I2S_DSP_WS_DET_ERR_CNT_EN
    chk("t3_cnt", 32'(bus.err_cnt_o), 32'd1);
`endif

    // 4: next pulse 20 edges after the resync -> 4 gap edges, still locked
    for (int g = 0; g < 4; g++)
      step($sformatf("t4_gap%0d", g), 1'b0, ex(0, 0, 0, 0, 0, 1, 0));
    run("t4_rise", 0, 0, 8, 16, 0);

    // 5: ws held 3 edges: one frame start, one error
    step("t5_str1", 1'b1, ex(1, 1, 0, 0, 0, 1, 1));
    step("t5_str2", 1'b1, ex(1, 2, 0, 0, 0, 1, 0));
    run("t5_rest", 3, 15, 8, 16, -1);
`ifdef I2S_DSP_WS_DET_ERR_CNT_EN
    chk("t5_cnt", 32'(bus.err_cnt_o), 32'd2);
`endif

    // 6: bits 7->15 mid-frame applies only at the next frame start
    run("t6_a", 0, 2, 8, 16, 0);
    bus.cfg_num_bits_i = 5'd15;
    run("t6_b", 3, 15, 8, 16, -1);
    run("t6_c", 0, 16, 16, 32, 0);
    // disable together with a rise: disable wins, everything drops
    bus.cfg_en_i = 1'b0;
    step("t6_dis", 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
    step("t6_idle", 1'b0, ex(0, 0, 0, 0, 0, 0, 0));
`ifdef I2S_DSP_WS_DET_ERR_CNT_EN
    chk("t6_cnt", 32'(bus.err_cnt_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
